// File: rtl/alu_rr_scheduler.sv
// alu_rr_scheduler: round-robin front end that shares one combinational ALU between NREQ requesters.
// Latency: operands registered on the accept edge, result captured one clock later, rsp_valid 2 clocks after accept.
// Backpressure: holds rsp_valid/rsp_id/rsp_data until rsp_ready; req_ready only in IDLE, so peak is one op per 3 cycles.
// Optional build macro ALU_SCHED_LOCK_EN adds req_lock: a locked winner keeps the round-robin pointer on itself.
module alu_rr_scheduler #(
  parameter  int NREQ  = 4,
  parameter  int WIDTH = 1,
  localparam int IDW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NREQ-1:0]         req_valid,
  output logic [NREQ-1:0]         req_ready,
  input  logic [NREQ*WIDTH-1:0]   req_a,
  input  logic [NREQ*WIDTH-1:0]   req_b,
  input  logic [NREQ*3-1:0]       req_op,
`ifdef ALU_SCHED_LOCK_EN
  input  logic [NREQ-1:0]         req_lock,
`endif
  output logic [WIDTH-1:0]        alu_a,
  output logic [WIDTH-1:0]        alu_b,
  output logic [2:0]              alu_choice,
  input  logic [WIDTH-1:0]        alu_out,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [IDW-1:0]          rsp_id,
  output logic [WIDTH-1:0]        rsp_data
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [IDW-1:0]   ptr_q, ptr_d;
  logic [WIDTH-1:0] alu_a_q, alu_a_d;
  logic [WIDTH-1:0] alu_b_q, alu_b_d;
  logic [2:0]       alu_choice_q, alu_choice_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic [IDW-1:0]   rsp_id_q, rsp_id_d;
  logic [WIDTH-1:0] rsp_data_q, rsp_data_d;
  // Set by reset, cleared one cycle later: keeps req_ready low for the first cycle out of reset.
  logic             boot_q;
  // High when the transaction in flight must leave the pointer on its own requester.
  logic             hold_ptr;
  logic             lock_d;

  logic             win_vld;
  logic [IDW-1:0]   win_id;

  // Candidate index k positions after base, wrapping at NREQ (NREQ need not be a power of two).
  function automatic logic [IDW-1:0] rr_idx(input logic [IDW-1:0] base, input int k);
    int sum;
    sum = int'(base) + k;
    if (sum >= NREQ) sum = sum - NREQ;
    return IDW'(sum);
  endfunction

  // Pointer value after serving id: the requester just above it, wrapping to 0.
  function automatic logic [IDW-1:0] next_id(input logic [IDW-1:0] id);
    return (id == IDW'(NREQ - 1)) ? '0 : id + 1'b1;
  endfunction

`ifdef ALU_SCHED_LOCK_EN
  logic lock_q;
  assign hold_ptr = lock_q;

  // Lock flag: taken from the winner's req_lock at every acceptance, cleared by reset.
  always_ff @(posedge clk) begin
    if (rst) lock_q <= 1'b0;
    else     lock_q <= lock_d;
  end
`else
  assign hold_ptr = 1'b0;
`endif

  // Round-robin search: first valid requester starting at ptr and walking upward modulo NREQ.
  always_comb begin
    win_vld = 1'b0;
    win_id  = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (!win_vld && req_valid[rr_idx(ptr_q, k)]) begin
        win_vld = 1'b1;
        win_id  = rr_idx(ptr_q, k);
      end
    end
  end

  // FSM next state, operand/result capture and the combinational one-hot accept.
  always_comb begin
    state_d      = state_q;
    ptr_d        = ptr_q;
    alu_a_d      = alu_a_q;
    alu_b_d      = alu_b_q;
    alu_choice_d = alu_choice_q;
    rsp_valid_d  = rsp_valid_q;
    rsp_id_d     = rsp_id_q;
    rsp_data_d   = rsp_data_q;
    lock_d       = hold_ptr;
    req_ready    = '0;
    case (state_q)
      ST_IDLE: begin
        // No accept while reset is applied or in the first cycle after it.
        if (win_vld && !boot_q && !rst) begin
          req_ready[win_id] = 1'b1;
          alu_a_d           = req_a[win_id*WIDTH +: WIDTH];
          alu_b_d           = req_b[win_id*WIDTH +: WIDTH];
          alu_choice_d      = req_op[win_id*3 +: 3];
          rsp_id_d          = win_id;
`ifdef ALU_SCHED_LOCK_EN
          lock_d            = req_lock[win_id];
`endif
          state_d           = ST_EXEC;
        end
      end
      ST_EXEC: begin
        // alu_* have been stable the whole cycle, so alu_out is settled here.
        rsp_data_d  = alu_out;
        rsp_valid_d = 1'b1;
        state_d     = ST_RESP;
      end
      ST_RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          // A locked winner keeps the pointer on itself so it wins the next IDLE if still requesting.
          ptr_d       = hold_ptr ? rsp_id_q : next_id(rsp_id_q);
          state_d     = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous reset; reset aborts any transaction in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      ptr_q        <= '0;
      alu_a_q      <= '0;
      alu_b_q      <= '0;
      alu_choice_q <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_id_q     <= '0;
      rsp_data_q   <= '0;
      boot_q       <= 1'b1;
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      alu_a_q      <= alu_a_d;
      alu_b_q      <= alu_b_d;
      alu_choice_q <= alu_choice_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_id_q     <= rsp_id_d;
      rsp_data_q   <= rsp_data_d;
      boot_q       <= 1'b0;
    end
  end

  assign alu_a      = alu_a_q;
  assign alu_b      = alu_b_q;
  assign alu_choice = alu_choice_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_id     = rsp_id_q;
  assign rsp_data   = rsp_data_q;

endmodule

// File: tb/tb_alu_rr_scheduler.sv
// Bench for alu_rr_scheduler: NREQ=4, WIDTH=4, with a behavioural ALU on the alu_* port.
// Table of single-request vectors plus hand-written sequences for RR order, wrap, backpressure and reset.
// Every accepted request pushes its expected {id, data} to a queue; each response handshake pops and compares.
module tb_alu_rr_scheduler;
  localparam int NREQ  = 4;
  localparam int WIDTH = 4;
  localparam int IDW   = 2;

  logic                  clk = 1'b0;
  logic                  rst;
  logic [NREQ-1:0]       req_valid;
  logic [NREQ-1:0]       req_ready;
  logic [NREQ*WIDTH-1:0] req_a;
  logic [NREQ*WIDTH-1:0] req_b;
  logic [NREQ*3-1:0]     req_op;
  logic [WIDTH-1:0]      alu_a;
  logic [WIDTH-1:0]      alu_b;
  logic [2:0]            alu_choice;
  logic [WIDTH-1:0]      alu_out;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [IDW-1:0]        rsp_id;
  logic [WIDTH-1:0]      rsp_data;
`ifdef ALU_SCHED_LOCK_EN
  logic [NREQ-1:0]       req_lock;
`endif

  int checks = 0;
  int errors = 0;
  int cyc_n  = 0;

  typedef struct {
    int               id;
    logic [WIDTH-1:0] data;
  } exp_t;
  exp_t sb_q[$];
  int   grant_q[$];
  int   grant_cyc_q[$];

  typedef struct {
    int               id;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [2:0]       op;
    logic [WIDTH-1:0] exp;
  } vec_t;
  vec_t tbl[8];

  always #5 clk = ~clk;

  // Reference ALU placed on the shared-ALU port.
  function automatic logic [WIDTH-1:0] alu_f(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                             input logic [2:0] op);
    case (op)
      3'd0:    return a + b;
      3'd1:    return a - b;
      3'd2:    return a & b;
      3'd3:    return a | b;
      3'd4:    return a ^ b;
      3'd5:    return ~a;
      3'd6:    return {a[WIDTH-2:0], 1'b0};
      default: return a;
    endcase
  endfunction

  assign alu_out = alu_f(alu_a, alu_b, alu_choice);

  alu_rr_scheduler #(.NREQ(NREQ), .WIDTH(WIDTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_a      (req_a),
    .req_b      (req_b),
    .req_op     (req_op),
`ifdef ALU_SCHED_LOCK_EN
    .req_lock   (req_lock),
`endif
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_choice (alu_choice),
    .alu_out    (alu_out),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_id     (rsp_id),
    .rsp_data   (rsp_data)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc_n);
    end
  endtask

  // Per-cycle observer, called once per cycle after inputs are set and before the rising edge.
  task automatic monitor();
    exp_t e;
    cyc_n++;
    chk("ready_onehot0", 32'($countones(req_ready) <= 1), 32'd1);
    for (int i = 0; i < NREQ; i++) begin
      if (req_valid[i] && req_ready[i]) begin
        e.id   = i;
        e.data = alu_f(req_a[i*WIDTH +: WIDTH], req_b[i*WIDTH +: WIDTH], req_op[i*3 +: 3]);
        sb_q.push_back(e);
        grant_q.push_back(i);
        grant_cyc_q.push_back(cyc_n);
      end
    end
    if (rsp_valid && rsp_ready) begin
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_unexpected: response id %0d with nothing outstanding", rsp_id);
      end else begin
        e = sb_q.pop_front();
        chk("sb_id", 32'(rsp_id), e.id);
        chk("sb_data", 32'(rsp_data), 32'(e.data));
      end
    end
  endtask

  // One cycle = nxt; set inputs; smp; inline checks.
  task automatic nxt();
    @(negedge clk);
  endtask

  task automatic smp();
    #1;
    monitor();
  endtask

  // Runs cycles with the current inputs until n more grants are seen (inputs must already be set).
  task automatic run_grants(input int n);
    int target;
    int budget;
    target = grant_q.size() + n;
    budget = 12 * n;
    smp();
    while (grant_q.size() < target && budget > 0) begin
      nxt();
      smp();
      budget--;
    end
    if (grant_q.size() < target) begin
      checks++;
      errors++;
      $display("FAIL grant_timeout: got %0d grants expected %0d", grant_q.size(), target);
    end
  endtask

  task automatic drain();
    int budget;
    budget = 30;
    do begin
      nxt();
      req_valid = '0;
      rsp_ready = 1'b1;
      smp();
      budget--;
    end while ((sb_q.size() != 0 || rsp_valid) && budget > 0);
    chk("drain_empty", sb_q.size(), 0);
  endtask

  task automatic chk_grant(input string name, input int pos, input int exp_id);
    if (pos < grant_q.size()) chk(name, grant_q[pos], exp_id);
    else begin
      checks++;
      errors++;
      $display("FAIL %s: grant %0d missing, expected id %0d", name, pos, exp_id);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int base;
    logic [NREQ-1:0]  m;
    logic [IDW-1:0]   hold_id;
    logic [WIDTH-1:0] hold_data;

    tbl[0] = '{2, 4'h1, 4'h0, 3'd5, 4'hE};
    tbl[1] = '{0, 4'h3, 4'h5, 3'd0, 4'h8};
    tbl[2] = '{1, 4'h3, 4'h5, 3'd1, 4'hE};
    tbl[3] = '{3, 4'hC, 4'hA, 3'd2, 4'h8};
    tbl[4] = '{0, 4'hC, 4'hA, 3'd3, 4'hE};
    tbl[5] = '{1, 4'hC, 4'hA, 3'd4, 4'h6};
    tbl[6] = '{2, 4'h9, 4'h0, 3'd6, 4'h2};
    tbl[7] = '{3, 4'h7, 4'h1, 3'd7, 4'h7};

    rst = 1'b1;
    req_valid = '0;
    req_a = '0;
    req_b = '0;
    req_op = '0;
    rsp_ready = 1'b0;
`ifdef ALU_SCHED_LOCK_EN
    req_lock = '0;
`endif
    repeat (2) @(negedge clk);

    // Reset state, no accept during reset nor in the first cycle after it.
    nxt();
    req_valid = '1;
    req_a = 16'h4321;
    req_b = 16'h1234;
    req_op = 12'b101_011_010_001;
    smp();
    chk("rst_ready", req_ready, 0);
    nxt();
    rst = 1'b0;
    smp();
    chk("boot_ready", req_ready, 0);
    chk("rst_alu_a", alu_a, 0);
    chk("rst_alu_b", alu_b, 0);
    chk("rst_alu_choice", alu_choice, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_id", rsp_id, 0);
    chk("rst_rsp_data", rsp_data, 0);
    nxt();
    smp();
    chk("first_grant", req_ready, 4'b0001);
    drain();

    // Single-request vectors: accept, registered operands, result two clocks after accept.
    for (int v = 0; v < 8; v++) begin
      nxt();
      req_valid = '0;
      req_valid[tbl[v].id] = 1'b1;
      req_a[tbl[v].id*WIDTH +: WIDTH] = tbl[v].a;
      req_b[tbl[v].id*WIDTH +: WIDTH] = tbl[v].b;
      req_op[tbl[v].id*3 +: 3] = tbl[v].op;
      rsp_ready = 1'b1;
      smp();
      m = '0;
      m[tbl[v].id] = 1'b1;
      chk("tbl_ready", req_ready, m);
      nxt();
      req_valid = '0;
      smp();
      chk("tbl_alu_choice", alu_choice, tbl[v].op);
      chk("tbl_alu_a", alu_a, tbl[v].a);
      chk("tbl_alu_b", alu_b, tbl[v].b);
      chk("tbl_exec_no_rsp", rsp_valid, 0);
      nxt();
      smp();
      chk("tbl_rsp_valid", rsp_valid, 1);
      chk("tbl_rsp_id", rsp_id, tbl[v].id);
      chk("tbl_rsp_data", rsp_data, tbl[v].exp);
      nxt();
      smp();
      chk("tbl_rsp_done", rsp_valid, 0);
    end

    // Wrap-around: last served id 3, then 0 and 3 request -> 0 first, then 3.
    nxt();
    req_valid = 4'b1001;
    base = grant_q.size();
    run_grants(1);
    nxt();
    req_valid = 4'b1000;
    run_grants(1);
    chk_grant("wrap_first", base, 0);
    chk_grant("wrap_second", base + 1, 3);
    drain();

    // All four requesting continuously: 0,1,2,3,0 with one accept every 3 cycles.
    nxt();
    req_valid = 4'b1111;
    req_a = 16'h8F27;
    req_b = 16'h3C51;
    req_op = 12'b100_000_110_001;
    base = grant_q.size();
    run_grants(5);
    chk_grant("rr_g0", base, 0);
    chk_grant("rr_g1", base + 1, 1);
    chk_grant("rr_g2", base + 2, 2);
    chk_grant("rr_g3", base + 3, 3);
    chk_grant("rr_g4", base + 4, 0);
    for (int g = 1; g < 5; g++) begin
      if (base + g < grant_cyc_q.size())
        chk("rr_spacing", grant_cyc_q[base + g] - grant_cyc_q[base + g - 1], 3);
    end
    drain();

    // Backpressure: response held for 5 cycles, no accept while stalled, then pointer moves to 2.
    nxt();
    req_valid = 4'b0010;
    req_a[1*WIDTH +: WIDTH] = 4'h6;
    req_b[1*WIDTH +: WIDTH] = 4'h3;
    req_op[1*3 +: 3] = 3'd1;
    rsp_ready = 1'b0;
    smp();
    chk("bp_ready", req_ready, 4'b0010);
    nxt();
    req_valid = 4'b1111;
    smp();
    chk("bp_exec_ready", req_ready, 0);
    nxt();
    smp();
    chk("bp_rsp_valid", rsp_valid, 1);
    chk("bp_rsp_id", rsp_id, 1);
    chk("bp_rsp_data", rsp_data, 4'h3);
    hold_id = rsp_id;
    hold_data = rsp_data;
    for (int s = 0; s < 5; s++) begin
      nxt();
      smp();
      chk("bp_hold_valid", rsp_valid, 1);
      chk("bp_hold_id", rsp_id, 1);
      chk("bp_hold_data", rsp_data, 4'h3);
      chk("bp_hold_ready", req_ready, 0);
    end
    nxt();
    rsp_ready = 1'b1;
    smp();
    nxt();
    smp();
    chk("bp_next_grant", req_ready, 4'b0100);
    drain();

    // Reset in EXEC: response dropped, registers cleared, pointer back to 0.
    nxt();
    req_valid = 4'b1111;
    rsp_ready = 1'b1;
    smp();
    chk("rx_grant", req_ready, 4'b1000);
    nxt();
    rst = 1'b1;
    smp();
    chk("rx_exec_ready", req_ready, 0);
    nxt();
    smp();
    chk("rx_rsp_valid", rsp_valid, 0);
    chk("rx_alu_a", alu_a, 0);
    chk("rx_alu_b", alu_b, 0);
    chk("rx_alu_choice", alu_choice, 0);
    chk("rx_rsp_id", rsp_id, 0);
    sb_q.delete();
    nxt();
    rst = 1'b0;
    smp();
    chk("rx_boot_ready", req_ready, 0);
    nxt();
    smp();
    chk("rx_first_grant", req_ready, 4'b0001);
    drain();

`ifdef ALU_SCHED_LOCK_EN
    // Requester 1 locked with 0 and 1 requesting: 1,1,1. After the lock drops, 1 is served once
    // more unlocked (pointer still on it) and the pointer then moves past it to 0.
    nxt();
    req_valid = 4'b0011;
    req_lock = 4'b0010;
    base = grant_q.size();
    run_grants(3);
    nxt();
    req_lock = 4'b0000;
    run_grants(2);
    chk_grant("lock_g0", base, 1);
    chk_grant("lock_g1", base + 1, 1);
    chk_grant("lock_g2", base + 2, 1);
    chk_grant("lock_g3", base + 3, 1);
    chk_grant("lock_g4", base + 4, 0);
    drain();
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
